// File: rtl/multiword_adder_seq_pkg.sv
// Shared constants and FSM state encoding for the multiword adder sequencer.
package multiword_adder_seq_pkg;

  localparam int DEF_WIDTH = 32;
  localparam int DEF_BLOCK = 4;
  localparam int DEF_WORDS = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/multiword_adder_seq_bypass.sv
// BypassAdder_r: WIDTH-bit carry-skip adder built from BLOCK-bit ripple
// blocks. When every bit of a block propagates, the block carry-in skips
// straight to the block carry-out. WIDTH must be a multiple of BLOCK.
module BypassAdder_r #(
  parameter int WIDTH = 32,
  parameter int BLOCK = 4
) (
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Cin,
  output logic [WIDTH-1:0] Sum,
  output logic             Cout
);
  localparam int NBLK = WIDTH / BLOCK;

  // Carry into each block; entry NBLK is the adder carry-out.
  logic [NBLK:0] blk_c;

  assign blk_c[0] = Cin;
  assign Cout     = blk_c[NBLK];

  genvar gi;
  for (gi = 0; gi < NBLK; gi++) begin : g_blk
    logic [BLOCK-1:0] a_b;
    logic [BLOCK-1:0] b_b;
    logic [BLOCK-1:0] s_b;
    logic [BLOCK:0]   rc;
    logic             prop;

    assign a_b = A[gi*BLOCK +: BLOCK];
    assign b_b = B[gi*BLOCK +: BLOCK];

    // Ripple through the block to form the sum bits and the ripple carry-out.
    always_comb begin
      s_b   = '0;
      rc    = '0;
      rc[0] = blk_c[gi];
      for (int k = 0; k < BLOCK; k++) begin
        s_b[k]  = a_b[k] ^ b_b[k] ^ rc[k];
        rc[k+1] = (a_b[k] & b_b[k]) | ((a_b[k] ^ b_b[k]) & rc[k]);
      end
    end

    assign prop                = &(a_b ^ b_b);
    assign blk_c[gi+1]         = prop ? blk_c[gi] : rc[BLOCK];
    assign Sum[gi*BLOCK +: BLOCK] = s_b;
  end

endmodule

// File: rtl/multiword_adder_seq.sv
// Multiword adder/subtractor: runs a WIDTH*WORDS-bit operation through one
// shared WIDTH-bit carry-skip adder, one word per cycle, LSW first, with the
// word carry registered between cycles.
module multiword_adder_seq
  import multiword_adder_seq_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int BLOCK = DEF_BLOCK,
  parameter int WORDS = DEF_WORDS
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic                   sub,
  input  logic [WIDTH*WORDS-1:0] A,
  input  logic [WIDTH*WORDS-1:0] B,
  input  logic                   Cin,
  output logic                   busy,
  output logic                   done,
  output logic [WIDTH*WORDS-1:0] Sum,
  output logic                   Cout
);
  localparam int N     = WIDTH * WORDS;
  localparam int IDX_W = $clog2(WORDS);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WORDS - 1);

  state_t           state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             carry_q, carry_d;
  logic [N-1:0]     a_q, a_d;
  logic [N-1:0]     b_q, b_d;
  logic [N-1:0]     sum_q, sum_d;
  logic             cout_q, cout_d;

  logic [WIDTH-1:0] add_a, add_b, add_sum;
  logic             add_cout;

  // Present the current word pair to the shared adder.
  assign add_a = a_q[idx_q*WIDTH +: WIDTH];
  assign add_b = b_q[idx_q*WIDTH +: WIDTH];

  BypassAdder_r #(
    .WIDTH (WIDTH),
    .BLOCK (BLOCK)
  ) u_adder (
    .A    (add_a),
    .B    (add_b),
    .Cin  (carry_q),
    .Sum  (add_sum),
    .Cout (add_cout)
  );

  // Next-state, datapath updates and status outputs.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    carry_d = carry_q;
    a_d     = a_q;
    b_d     = b_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
    busy    = 1'b0;
    done    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          // Subtraction is A + ~B + 1, so invert B here and force the carry.
          a_d     = A;
          b_d     = sub ? ~B : B;
          carry_d = sub ? 1'b1 : Cin;
          idx_d   = '0;
          sum_d   = '0;
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        busy                          = 1'b1;
        sum_d[idx_q*WIDTH +: WIDTH]   = add_sum;
        carry_d                       = add_cout;
        if (idx_q == LAST_IDX) begin
          cout_d  = add_cout;
          state_d = ST_DONE;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      ST_DONE: begin
        busy    = 1'b1;
        done    = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and datapath registers; reset abandons any operation in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
      carry_q <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      carry_q <= carry_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
    end
  end

  assign Sum  = sum_q;
  assign Cout = cout_q;

endmodule

// File: tb/tb_multiword_adder_seq.sv
// Scoreboard bench for multiword_adder_seq: stimulus pushes expected results,
// a negedge monitor pops and compares on every done pulse.
module tb_multiword_adder_seq;
  localparam int WIDTH = 32;
  localparam int BLOCK = 4;
  localparam int WORDS = 4;
  localparam int N     = WIDTH * WORDS;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic         sub;
  logic [N-1:0] A;
  logic [N-1:0] B;
  logic         Cin;
  logic         busy;
  logic         done;
  logic [N-1:0] Sum;
  logic         Cout;

  typedef struct {
    logic [N-1:0] sum;
    logic         cout;
    int           dcyc;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;
  int   ndone = 0;
  int   ntxn  = 0;
  int   busy_run  = 0;
  int   last_busy = 0;

  multiword_adder_seq #(
    .WIDTH (WIDTH),
    .BLOCK (BLOCK),
    .WORDS (WORDS)
  ) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .sub   (sub),
    .A     (A),
    .B     (B),
    .Cin   (Cin),
    .busy  (busy),
    .done  (done),
    .Sum   (Sum),
    .Cout  (Cout)
  );

  always #5 clk = ~clk;

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  task automatic chk(input string nm, input logic [N:0] act, input logic [N:0] exp_v);
    total++;
    if (act !== exp_v) begin
      bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp_v);
    end
  endtask

  // Monitor: one compare set per done pulse, plus busy-run length tracking.
  initial forever begin
    exp_t e;
    @(negedge clk);
    if (rst) begin
      busy_run = 0;
    end else begin
      if (busy) busy_run++;
      else if (busy_run != 0) begin
        last_busy = busy_run;
        busy_run  = 0;
      end
      if (done) begin
        ndone++;
        if (sb.size() == 0) begin
          total++;
          bad++;
          $display("FAIL spurious_done: got done=1 at cycle %0d expected no pending op", cyc);
        end else begin
          e = sb.pop_front();
          ntxn++;
          chk("sum", {1'b0, Sum}, {1'b0, e.sum});
          chk("cout", {{N{1'b0}}, Cout}, {{N{1'b0}}, e.cout});
          chk("latency", N'(cyc), N'(e.dcyc));
          $display("txn %0d: sum=%h cout=%b cycle=%0d", ntxn, Sum, Cout, cyc);
        end
      end
    end
  end

  function automatic exp_t mk(input logic [N-1:0] es, input logic ec, input int c);
    exp_t e;
    e.sum  = es;
    e.cout = ec;
    e.dcyc = c + 1 + WORDS;
    return e;
  endfunction

  // Issue one operation at a negedge and wait until the DUT is idle-ready.
  task automatic issue(input logic [N-1:0] a, input logic [N-1:0] b, input logic ci,
                       input logic s, input logic [N-1:0] es, input logic ec);
    @(negedge clk);
    A = a; B = b; Cin = ci; sub = s; start = 1'b1;
    sb.push_back(mk(es, ec, cyc));
    @(negedge clk);
    start = 1'b0;
    A = ~a; B = ~b; Cin = ~ci; sub = ~s;
    repeat (WORDS) @(negedge clk);
  endtask

  initial begin
    logic [N-1:0] ones;
    logic [N-1:0] ra, rb;
    logic [N:0]   ref_r;
    logic         rc, rs;
    int           nd0;

    ones  = '1;
    rst   = 1'b1;
    start = 1'b0;
    sub   = 1'b0;
    A     = '0;
    B     = '0;
    Cin   = 1'b0;
    repeat (2) @(negedge clk);
    chk("reset_busy", {{N{1'b0}}, busy}, '0);
    chk("reset_done", {{N{1'b0}}, done}, '0);
    chk("reset_sum", {1'b0, Sum}, '0);
    chk("reset_cout", {{N{1'b0}}, Cout}, '0);
    rst = 1'b0;

    // Full carry chain, with busy length check.
    issue(ones, N'(1), 1'b0, 1'b0, '0, 1'b1);
    repeat (2) @(negedge clk);
    chk("busy_len", N'(last_busy), N'(WORDS + 1));

    // Cross-word carry and alternating patterns.
    issue({96'h0, 32'hFFFFFFFF}, N'(1), 1'b0, 1'b0, {64'h0, 32'h1, 32'h0}, 1'b0);
    issue({4{32'hAAAAAAAA}}, {4{32'h55555555}}, 1'b1, 1'b0, '0, 1'b1);

    // Subtraction.
    issue('0, N'(1), 1'b0, 1'b1, ones, 1'b0);
    issue({1'b1, {(N-1){1'b0}}}, N'(1), 1'b0, 1'b1, {1'b0, {(N-1){1'b1}}}, 1'b1);

    // Start while busy: held through RUN and DONE, then a new op right after done.
    nd0 = ndone;
    @(negedge clk);
    A = N'(5); B = N'(3); Cin = 1'b0; sub = 1'b0; start = 1'b1;
    sb.push_back(mk(N'(8), 1'b0, cyc));
    repeat (WORDS + 1) begin
      @(negedge clk);
      A = ones; B = ones; Cin = 1'b1; sub = 1'($urandom_range(0, 1)); start = 1'b1;
    end
    issue(N'(10), N'(4), 1'b0, 1'b1, N'(6), 1'b1);
    repeat (2) @(negedge clk);
    chk("busy_done_count", N'(ndone - nd0), N'(2));

    // Asynchronous reset mid-operation after two words.
    @(negedge clk);
    A = ones; B = ones; Cin = 1'b1; sub = 1'b0; start = 1'b1;
    sb.push_back(mk(ones, 1'b1, cyc));
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    #1 rst = 1'b1;
    #1;
    chk("midrst_busy", {{N{1'b0}}, busy}, '0);
    chk("midrst_done", {{N{1'b0}}, done}, '0);
    chk("midrst_sum", {1'b0, Sum}, '0);
    chk("midrst_cout", {{N{1'b0}}, Cout}, '0);
    void'(sb.pop_back());
    nd0 = ndone;
    @(negedge clk);
    rst = 1'b0;
    repeat (WORDS + 2) @(negedge clk);
    chk("midrst_no_done", N'(ndone), N'(nd0));
    issue(N'(7), N'(9), 1'b1, 1'b0, N'(17), 1'b0);

    // Random operations against a 129-bit reference.
    for (int i = 0; i < 1000; i++) begin
      ra = {$urandom, $urandom, $urandom, $urandom};
      rb = {$urandom, $urandom, $urandom, $urandom};
      rc = 1'($urandom_range(0, 1));
      rs = 1'($urandom_range(0, 1));
      if (rs) ref_r = {1'b0, ra} - {1'b0, rb} + {1'b1, {N{1'b0}}};
      else    ref_r = {1'b0, ra} + {1'b0, rb} + {{N{1'b0}}, rc};
      issue(ra, rb, rc, rs, ref_r[N-1:0], ref_r[N]);
    end

    // Drain the scoreboard with a bounded wait.
    for (int i = 0; i < 50 && sb.size() != 0; i++) @(negedge clk);
    chk("drain", N'(sb.size()), '0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
